// File: rtl/rca16_result_stage.sv
// Result capture FIFO for the 16-bit ripple-carry adder: stores Sum plus carry/zero/overflow flags.
// Optional macro RCA_STICKY_FLAGS_EN adds sticky carry/overflow flags with a synchronous clear.
module rca16_result_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         sum_i,
    input  logic                     cout_i,
    input  logic                     a_msb_i,
    input  logic                     b_msb_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic                     out_ovf,
`ifdef RCA_STICKY_FLAGS_EN
    input  logic                     clr_sticky,
    output logic                     sticky_carry,
    output logic                     sticky_ovf,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WIDTH + 3;

    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [EW-1:0]    head_reg, head_next;
    logic             push, pop;
    logic             in_zero, in_carry, in_ovf;
    logic [EW-1:0]    in_entry;

    assign in_ready  = (count_reg != CW'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign in_zero   = (sum_i == '0);
    assign in_carry  = cout_i;
    assign in_ovf    = (a_msb_i == b_msb_i) && (sum_i[WIDTH-1] != a_msb_i);
    assign in_entry  = {in_ovf, in_zero, in_carry, sum_i};

    assign wr_ptr_next = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
    assign rd_ptr_next = pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // The output registers are loaded with whatever will be at the head next cycle.
    // If the FIFO drains to the entry being written right now, take it from the input.
    always_comb begin
        head_next = head_reg;
        if (count_next != '0) begin
            if (push && ((count_reg - CW'(pop)) == '0)) begin
                head_next = in_entry;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

    assign out_sum   = head_reg[WIDTH-1:0];
    assign out_carry = head_reg[WIDTH];
    assign out_zero  = head_reg[WIDTH+1];
    assign out_ovf   = head_reg[WIDTH+2];
    assign count     = count_reg;

`ifdef RCA_STICKY_FLAGS_EN
    logic sticky_carry_reg, sticky_ovf_reg;

    // A setting push beats a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_carry_reg <= 1'b0;
            sticky_ovf_reg   <= 1'b0;
        end else begin
            if (push && in_carry) begin
                sticky_carry_reg <= 1'b1;
            end else if (clr_sticky) begin
                sticky_carry_reg <= 1'b0;
            end
            if (push && in_ovf) begin
                sticky_ovf_reg <= 1'b1;
            end else if (clr_sticky) begin
                sticky_ovf_reg <= 1'b0;
            end
        end
    end

    assign sticky_carry = sticky_carry_reg;
    assign sticky_ovf   = sticky_ovf_reg;
`endif

endmodule

// File: tb/tb_rca16_result_stage.sv
// Directed bench for rca16_result_stage (DEPTH=2); sticky-flag checks are built when RCA_STICKY_FLAGS_EN is defined.
module tb_rca16_result_stage;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_i;
    logic             cout_i;
    logic             a_msb_i;
    logic             b_msb_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_zero;
    logic             out_ovf;
    logic [$clog2(DEPTH):0] count;
`ifdef RCA_STICKY_FLAGS_EN
    logic             clr_sticky;
    logic             sticky_carry;
    logic             sticky_ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] q [$];

    always #5 clk = ~clk;

    rca16_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_i     (sum_i),
        .cout_i    (cout_i),
        .a_msb_i   (a_msb_i),
        .b_msb_i   (b_msb_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
`ifdef RCA_STICKY_FLAGS_EN
        .clr_sticky   (clr_sticky),
        .sticky_carry (sticky_carry),
        .sticky_ovf   (sticky_ovf),
`endif
        .count     (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] s, input logic c,
                         input logic am, input logic bm);
        in_valid = v;
        sum_i    = s;
        cout_i   = c;
        a_msb_i  = am;
        b_msb_i  = bm;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef RCA_STICKY_FLAGS_EN
        clr_sticky = 1'b0;
`endif
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_count",     count,     0);
        check("rst_out_sum",   out_sum,   0);
        check("rst_out_carry", out_carry, 0);
        check("rst_out_zero",  out_zero,  0);
        check("rst_out_ovf",   out_ovf,   0);
        rst_n = 1'b1;
        step();

        // single push then pop
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        check("single_out_valid", out_valid, 1);
        check("single_out_sum",   out_sum,   32'h1234);
        check("single_zero",      out_zero,  0);
        check("single_carry",     out_carry, 0);
        check("single_ovf",       out_ovf,   0);
        check("single_count",     count,     1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_pop_count", count,     0);
        check("single_pop_valid", out_valid, 0);
        check("single_hold_sum",  out_sum,   32'h1234);

        // 7FFF + 7FFF = FFFE: signed overflow
        drive(1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        check("ovf_sum",   out_sum,   32'hFFFE);
        check("ovf_ovf",   out_ovf,   1);
        check("ovf_zero",  out_zero,  0);
        check("ovf_carry", out_carry, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ovf_pop_count", count, 0);

        // FFFF + 0001 = 0 with carry out
        drive(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        check("zc_zero",  out_zero,  1);
        check("zc_carry", out_carry, 1);
        check("zc_ovf",   out_ovf,   0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("zc_pop_count", count, 0);

        // fill with back-pressure, third value held upstream
        drive(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        step();
        sum_i = 16'hBBBB;
        step();
        check("fill_count",    count,    2);
        check("fill_in_ready", in_ready, 0);
        check("fill_head",     out_sum,  32'hAAAA);
        sum_i = 16'hCCCC;
        step();
        check("full_hold_count", count,    2);
        check("full_hold_head",  out_sum,  32'hAAAA);
        check("full_hold_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        check("drain1_count", count,    1);
        check("drain1_head",  out_sum,  32'hBBBB);
        check("drain1_ready", in_ready, 1);
        step();
        check("drain2_count", count,   1);
        check("drain2_head",  out_sum, 32'hCCCC);
        in_valid = 1'b0;
        step();
        check("drain3_count", count,     0);
        check("drain3_valid", out_valid, 0);
        check("drain3_hold",  out_sum,   32'hCCCC);
        out_ready = 1'b0;

        // concurrent push+pop at count=1 with pointer wrap
        drive(1'b1, 16'h5000, 1'b0, 1'b0, 1'b0);
        step();
        q.push_back(16'h5000);
        check("conc_init_head", out_sum, 32'h5000);
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            sum_i = 16'h5000 + 16'(i * 16'h0101);
            step();
            q.push_back(sum_i);
            void'(q.pop_front());
            check($sformatf("conc_count_%0d", i), count, 1);
            check($sformatf("conc_head_%0d", i), out_sum, 32'(q[0]));
        end
        in_valid = 1'b0;
        step();
        void'(q.pop_front());
        check("conc_drain_count", count, 0);
        out_ready = 1'b0;

        // asynchronous reset mid-traffic
        drive(1'b1, 16'h1111, 1'b1, 1'b0, 1'b0);
        step();
        sum_i = 16'h2222;
        step();
        in_valid = 1'b0;
        check("mid_pre_count", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready,  1);
        check("mid_rst_count", count,     0);
        check("mid_rst_sum",   out_sum,   0);
        check("mid_rst_carry", out_carry, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_count", count, 0);

`ifdef RCA_STICKY_FLAGS_EN
        check("sticky_rst_ovf",   sticky_ovf,   0);
        check("sticky_rst_carry", sticky_carry, 0);
        drive(1'b1, 16'h8000, 1'b1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        check("sticky_set_ovf",   sticky_ovf,   1);
        check("sticky_set_carry", sticky_carry, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("sticky_after_pop", sticky_ovf, 1);
        clr_sticky = 1'b1;
        drive(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        check("sticky_set_wins_ovf", sticky_ovf,   1);
        check("sticky_clr_carry",    sticky_carry, 0);
        out_ready = 1'b1;
        step();
        clr_sticky = 1'b0;
        out_ready  = 1'b0;
        check("sticky_clr_ovf", sticky_ovf, 0);
        check("sticky_count",   count,      0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
